// File: rtl/relin_key_writer_pkg.sv
// Shared types and sizing helpers for the relinearization-key register file
// (writer side and tile loader).
package relin_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } relin_wr_state_e;

    localparam int DEF_TILE_WIDTH = 8;
    localparam int DEF_KEY_LENGTH = 512;
    localparam int DEF_NUM_KEYS   = 8;
    localparam int DEF_DATA_WIDTH = 64;

    typedef logic [DEF_TILE_WIDTH-1:0][DEF_DATA_WIDTH-1:0] relin_tile_t;

    function automatic int beatsTotal(input int length, input int tile, input int numKeys);
        return 2 * numKeys * length / tile;
    endfunction

    // One spare top bit so the address width matches the loader's address bus.
    function automatic int addrW(input int length);
        return $clog2(length) + 1;
    endfunction

    function automatic int keyW(input int numKeys);
        return (numKeys > 1) ? $clog2(numKeys) : 1;
    endfunction

endpackage

// File: rtl/relin_key_writer_if.sv
// Key-tile input stream plus register-file write port of the relin key writer.
interface relin_key_writer_if #(
    parameter int TILE       = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEY_W      = 3,
    parameter int ADDR_W     = 10
);
    logic                             in_valid;
    logic                             in_ready;
    logic [TILE-1:0][DATA_WIDTH-1:0]  in_tile;
    logic                             wr_en;
    logic                             wr_c_sel;
    logic [KEY_W-1:0]                 wr_key;
    logic [ADDR_W-1:0]                wr_address;
    logic [TILE-1:0][DATA_WIDTH-1:0]  wr_tile;

    modport slave (
        input  in_valid, in_tile,
        output in_ready, wr_en, wr_c_sel, wr_key, wr_address, wr_tile
    );

    modport master (
        output in_valid, in_tile,
        input  in_ready, wr_en, wr_c_sel, wr_key, wr_address, wr_tile
    );
endinterface

// File: rtl/relin_key_writer_addr_counter.sv
// Nested (c_sel, key, address) counter; address steps by one tile and is innermost.
module relin_key_addr_counter
    import relin_key_pkg::*;
#(
    parameter int LENGTH   = DEF_KEY_LENGTH,
    parameter int TILE     = DEF_TILE_WIDTH,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEY_W    = keyW(DEF_NUM_KEYS),
    parameter int ADDR_W   = addrW(DEF_KEY_LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic              cSel_o,
    output logic [KEY_W-1:0]  key_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic              cSel_q, cSel_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addrLast, keyLast;

    assign addrLast = (addr_q == ADDR_W'(LENGTH - TILE));
    assign keyLast  = (key_q == KEY_W'(NUM_KEYS - 1));

    always_comb begin
        cSel_d = cSel_q;
        key_d  = key_q;
        addr_d = addr_q;
        if (clr_i) begin
            cSel_d = 1'b0;
            key_d  = '0;
            addr_d = '0;
        end else if (inc_i) begin
            if (addrLast) begin
                addr_d = '0;
                if (keyLast) begin
                    key_d  = '0;
                    cSel_d = ~cSel_q;
                end else begin
                    key_d = key_q + 1'b1;
                end
            end else begin
                addr_d = addr_q + ADDR_W'(TILE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cSel_q <= 1'b0;
            key_q  <= '0;
            addr_q <= '0;
        end else begin
            cSel_q <= cSel_d;
            key_q  <= key_d;
            addr_q <= addr_d;
        end
    end

    assign cSel_o = cSel_q;
    assign key_o  = key_q;
    assign addr_o = addr_q;
    assign last_o = cSel_q && keyLast && addrLast;

endmodule

// File: rtl/relin_key_writer.sv
// Write side of the relinearization-key register file: turns a stream of key
// tiles into registered (c_sel, key, address) writes and flags a complete image.
module relin_key_writer
    import relin_key_pkg::*;
#(
    parameter int RELIN_KEY_TILE_WIDTH = DEF_TILE_WIDTH,
    parameter int RELIN_KEY_LENGTH     = DEF_KEY_LENGTH,
    parameter int NUM_RELIN_KEYS       = DEF_NUM_KEYS,
    parameter int DATA_WIDTH           = DEF_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    relin_key_writer_if.slave bus,
    output logic            busy_o,
    output logic            keys_loaded_o
);

    localparam int KEY_W  = keyW(NUM_RELIN_KEYS);
    localparam int ADDR_W = addrW(RELIN_KEY_LENGTH);

    relin_wr_state_e state_q, state_d;
    logic              accept;
    logic              ctrCSel, ctrLast;
    logic [KEY_W-1:0]  ctrKey;
    logic [ADDR_W-1:0] ctrAddr;

    logic                                       wrEn_q, wrCSel_q, keysLoaded_q;
    logic [KEY_W-1:0]                           wrKey_q;
    logic [ADDR_W-1:0]                          wrAddr_q;
    logic [RELIN_KEY_TILE_WIDTH-1:0][DATA_WIDTH-1:0] wrTile_q;

    relin_key_addr_counter #(
        .LENGTH   (RELIN_KEY_LENGTH),
        .TILE     (RELIN_KEY_TILE_WIDTH),
        .NUM_KEYS (NUM_RELIN_KEYS),
        .KEY_W    (KEY_W),
        .ADDR_W   (ADDR_W)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_i),
        .inc_i  (accept),
        .cSel_o (ctrCSel),
        .key_o  (ctrKey),
        .addr_o (ctrAddr),
        .last_o (ctrLast)
    );

    // A start cycle restarts the load, so any beat offered alongside it is dropped.
    always_comb begin
        state_d = state_q;
        accept  = bus.in_valid && (state_q == LOAD) && !start_i;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD: begin
                if (start_i)              state_d = LOAD;
                else if (accept && ctrLast) state_d = DONE;
            end
            DONE:    if (start_i) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrEn_q       <= 1'b0;
            wrCSel_q     <= 1'b0;
            wrKey_q      <= '0;
            wrAddr_q     <= '0;
            wrTile_q     <= '0;
            keysLoaded_q <= 1'b0;
        end else begin
            wrEn_q <= accept;
            if (accept) begin
                wrCSel_q <= ctrCSel;
                wrKey_q  <= ctrKey;
                wrAddr_q <= ctrAddr;
                wrTile_q <= bus.in_tile;
            end
            if (start_i)                keysLoaded_q <= 1'b0;
            else if (accept && ctrLast) keysLoaded_q <= 1'b1;
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.wr_en      = wrEn_q;
    assign bus.wr_c_sel   = wrCSel_q;
    assign bus.wr_key     = wrKey_q;
    assign bus.wr_address = wrAddr_q;
    assign bus.wr_tile    = wrTile_q;
    assign busy_o         = (state_q == LOAD);
    assign keys_loaded_o  = keysLoaded_q;

endmodule
